// File: rtl/output_mode_pkg.sv
// Shared types and mode decode for the output mode sequencer.
package output_mode_pkg;

  typedef enum logic [2:0] {
    ModeOff      = 3'd0,
    ModePwm      = 3'd1,
    ModeR2r      = 3'd2,
    ModeSawtooth = 3'd3,
    ModeBuzzer   = 3'd4,
    ModeChrip    = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    StOff,
    StActive,
    StQualify,
    StGuard
  } state_e;

  typedef struct packed {
    logic pwm;
    logic r2r;
    logic buzzer;
    logic chrip;
    logic sawtooth;
  } mode_ctrl_t;

  function automatic mode_ctrl_t decode_mode(logic [2:0] code);
    mode_ctrl_t ctrl;
    ctrl = '0;
    case (code)
      ModePwm:      ctrl.pwm = 1'b1;
      ModeR2r:      ctrl.r2r = 1'b1;
      ModeSawtooth: begin
        ctrl.pwm      = 1'b1;
        ctrl.sawtooth = 1'b1;
      end
      ModeBuzzer:   ctrl.buzzer = 1'b1;
      ModeChrip:    begin
        ctrl.buzzer = 1'b1;
        ctrl.chrip  = 1'b1;
      end
      default:      ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/mode_qualifier.sv
// Candidate capture and stability counting for requested mode codes.
module mode_qualifier
  import output_mode_pkg::*;
#(
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned NUM_MODES     = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SEL_W-1:0] mode_select_i,
  input  logic [SEL_W-1:0] active_mode_i,
  input  logic             qualifying_i,
  input  logic             hold_i,
  input  logic             clear_i,
  output logic [SEL_W-1:0] candidate_o,
  output logic             request_o,
  output logic             abort_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  logic [CntW-1:0]  count_q, count_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic             legal, match;

  assign legal       = mode_select_i < SEL_W'(NUM_MODES);
  assign request_o   = legal && (mode_select_i != active_mode_i);
  assign match       = mode_select_i == cand_q;
  assign done_o      = count_q >= CntW'(STABLE_CYCLES);
  assign abort_o     = qualifying_i && !done_o && !match && !request_o;
  assign candidate_o = cand_q;

  always_comb begin
    count_d = count_q;
    cand_d  = cand_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      if (qualifying_i) begin
        // Once qualified the count freezes until the sequencer leaves QUALIFY.
        if (!done_o) begin
          if (match) begin
            count_d = count_q + CntW'(1);
          end else if (request_o) begin
            cand_d  = mode_select_i;
            count_d = CntW'(1);
          end else begin
            count_d = '0;
          end
        end
      end else if (request_o) begin
        cand_d  = mode_select_i;
        count_d = CntW'(1);
      end else begin
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      cand_q  <= '0;
    end else begin
      count_q <= count_d;
      cand_q  <= cand_d;
    end
  end

endmodule

// File: rtl/output_mode_sequencer.sv
// Glitch-free output mode switching with stability qualification.
// OUTPUT_MODE_DEADTIME_EN inserts an all-off guard interval between modes.
module output_mode_sequencer
  import output_mode_pkg::*;
#(
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned NUM_MODES     = 6,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GUARD_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] mode_select,
  input  logic             force_off,
  output logic             pwm_enable,
  output logic             r2r_enable,
  output logic             buzzer_enable,
  output logic             chrip_mode,
  output logic             sawtooth_mode,
  output logic [SEL_W-1:0] active_mode,
  output logic             switching,
  output logic             mode_changed
);

  // Assert asynchronously, release two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e           state_q;
  logic [SEL_W-1:0] active_q;
  mode_ctrl_t       ctrl_q;
  logic             changed_q;
  logic [SEL_W-1:0] candidate;
  logic             request, abort, done;
  mode_ctrl_t       cand_ctrl;

  assign cand_ctrl = decode_mode(candidate[2:0]);

  mode_qualifier #(
    .SEL_W        (SEL_W),
    .NUM_MODES    (NUM_MODES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_qualifier (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mode_select_i(mode_select),
    .active_mode_i(active_q),
    .qualifying_i (state_q == StQualify),
    .hold_i       (state_q == StGuard),
    .clear_i      (force_off),
    .candidate_o  (candidate),
    .request_o    (request),
    .abort_o      (abort),
    .done_o       (done)
  );

`ifdef OUTPUT_MODE_DEADTIME_EN
  localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);
  logic [GuardW-1:0] guard_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      active_q  <= '0;
      ctrl_q    <= '0;
      changed_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      changed_q <= 1'b0;
      if (force_off) begin
        state_q  <= StOff;
        active_q <= '0;
        ctrl_q   <= '0;
        guard_q  <= '0;
      end else begin
        case (state_q)
          StOff, StActive: begin
            if (request) state_q <= StQualify;
          end
          StQualify: begin
            if (done) begin
              state_q <= StGuard;
              ctrl_q  <= '0;
              guard_q <= GuardW'(1);
            end else if (abort) begin
              state_q <= (active_q == '0) ? StOff : StActive;
            end
          end
          StGuard: begin
            if (guard_q >= GuardW'(GUARD_CYCLES)) begin
              state_q   <= (candidate == '0) ? StOff : StActive;
              active_q  <= candidate;
              ctrl_q    <= cand_ctrl;
              changed_q <= 1'b1;
              guard_q   <= '0;
            end else begin
              guard_q <= guard_q + GuardW'(1);
            end
          end
          default: state_q <= StOff;
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOff;
      active_q  <= '0;
      ctrl_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (force_off) begin
        state_q  <= StOff;
        active_q <= '0;
        ctrl_q   <= '0;
      end else begin
        case (state_q)
          StOff, StActive: begin
            if (request) state_q <= StQualify;
          end
          StQualify: begin
            if (done) begin
              state_q   <= (candidate == '0) ? StOff : StActive;
              active_q  <= candidate;
              ctrl_q    <= cand_ctrl;
              changed_q <= 1'b1;
            end else if (abort) begin
              state_q <= (active_q == '0) ? StOff : StActive;
            end
          end
          default: state_q <= StOff;
        endcase
      end
    end
  end
`endif

  assign pwm_enable    = ctrl_q.pwm;
  assign r2r_enable    = ctrl_q.r2r;
  assign buzzer_enable = ctrl_q.buzzer;
  assign chrip_mode    = ctrl_q.chrip;
  assign sawtooth_mode = ctrl_q.sawtooth;
  assign active_mode   = active_q;
  assign switching     = (state_q == StQualify) || (state_q == StGuard);
  assign mode_changed  = changed_q;

endmodule

// File: tb/tb_output_mode_sequencer.sv
// Randomized and directed bench for output_mode_sequencer against a behavioural model.
module tb_output_mode_sequencer;

  localparam int NumModes = 6;
  localparam int Stable   = 4;
  localparam int Guard    = 8;
`ifdef OUTPUT_MODE_DEADTIME_EN
  localparam int Live = Stable + Guard;
`else
  localparam int Live = Stable;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       force_off = 1'b0;
  logic [2:0] mode_select = 3'd0;
  logic       pwm_enable, r2r_enable, buzzer_enable, chrip_mode, sawtooth_mode;
  logic [2:0] active_mode;
  logic       switching, mode_changed;
  logic [9:0] dut_vec;

  output_mode_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mode_select  (mode_select),
    .force_off    (force_off),
    .pwm_enable   (pwm_enable),
    .r2r_enable   (r2r_enable),
    .buzzer_enable(buzzer_enable),
    .chrip_mode   (chrip_mode),
    .sawtooth_mode(sawtooth_mode),
    .active_mode  (active_mode),
    .switching    (switching),
    .mode_changed (mode_changed)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pwm_enable, r2r_enable, buzzer_enable, chrip_mode, sawtooth_mode,
                    active_mode, switching, mode_changed};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // {pwm, r2r, buzzer, chrip, sawtooth} for each legal mode code
  logic [4:0] ctrl_tbl [0:5] = '{5'b00000, 5'b10000, 5'b01000, 5'b10001, 5'b00100, 5'b00110};

  // Model: mode driving outputs, pending candidate, run of identical samples, dead time left.
  int m_active = 0;
  int m_cand   = 0;
  int m_streak = 0;
  int m_guard  = 0;
  bit m_changed = 1'b0;

  task automatic model_step(input int sel, input bit frc);
    bit req;
    req = (sel < NumModes) && (sel != m_active);
    m_changed = 1'b0;
    if (frc) begin
      m_active = 0;
      m_streak = 0;
      m_guard  = 0;
    end else if (m_guard > 0) begin
      m_guard--;
      if (m_guard == 0) begin
        m_active  = m_cand;
        m_changed = 1'b1;
      end
    end else if (m_streak >= Stable) begin
`ifdef OUTPUT_MODE_DEADTIME_EN
      m_guard = Guard;
`else
      m_active  = m_cand;
      m_changed = 1'b1;
`endif
      m_streak = 0;
    end else if (m_streak > 0) begin
      if (sel == m_cand) m_streak++;
      else if (req) begin
        m_cand   = sel;
        m_streak = 1;
      end else m_streak = 0;
    end else if (req) begin
      m_cand   = sel;
      m_streak = 1;
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [4:0] ctrl;
    ctrl = (m_guard > 0) ? 5'b00000 : ctrl_tbl[m_active];
    return {ctrl, 3'(m_active), (m_streak > 0) || (m_guard > 0), m_changed};
  endfunction

  task automatic cycle(input string tag, input logic [2:0] sel, input logic frc);
    mode_select = sel;
    force_off   = frc;
    @(posedge clk);
    model_step(int'(sel), frc);
    #1;
    check(tag, 32'(dut_vec), 32'(exp_vec()));
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1 check("reset_async", 32'(dut_vec), 32'd0);
    m_active = 0; m_cand = 0; m_streak = 0; m_guard = 0; m_changed = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_reset", 3'd0, 1'b0);
  endtask

  task automatic goto_mode(input logic [2:0] sel);
    for (int i = 0; i < Live + 2; i++) cycle("goto", sel, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          len;
    logic [2:0]  s;
    logic [2:0]  seq_c [0:4];
    seq_c = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd3};

    mode_select = 3'd0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 32'(dut_vec), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("idle", 3'd0, 1'b0);

    // Off -> 1: outputs live exactly at E(Live)
    for (int e = 0; e <= Live + 2; e++) begin
      cycle("a_model", 3'd1, 1'b0);
      check("a_pwm", 32'(pwm_enable), 32'(e >= Live));
      check("a_changed", 32'(mode_changed), 32'(e == Live));
    end

    // 1 -> 2: pwm drops at E(Stable), r2r rises at E(Live)
    for (int e = 0; e <= Live + 1; e++) begin
      cycle("b_model", 3'd2, 1'b0);
      check("b_r2r", 32'(r2r_enable), 32'(e >= Live));
      check("b_pwm", 32'(pwm_enable), 32'(e < Stable));
    end

    // Mode 3 with a two-sample glitch to 4
    goto_mode(3'd3);
    for (int i = 0; i < 5; i++) begin
      cycle("c_model", seq_c[i], 1'b0);
      check("c_outputs", 32'({pwm_enable, sawtooth_mode, active_mode}), 32'({2'b11, 3'd3}));
      check("c_switching", 32'(switching), 32'(i < 2));
      check("c_changed", 32'(mode_changed), 32'd0);
    end

    // Illegal code held in mode 1
    goto_mode(3'd1);
    for (int i = 0; i < 20; i++) begin
      cycle("d_model", 3'd7, 1'b0);
      check("d_pwm_sw", 32'({pwm_enable, switching}), 32'(2'b10));
    end

    // Mode 2, request 5, force_off once qualified
    goto_mode(3'd2);
    for (int i = 0; i < Stable + 2; i++) cycle("e_req", 3'd5, 1'b0);
    cycle("e_force", 3'd5, 1'b1);
    check("e_force_off", 32'({dut_vec[9:5], active_mode, mode_changed}), 32'd0);
    for (int e = 0; e <= Live + 1; e++) begin
      cycle("e_model", 3'd5, 1'b0);
      check("e_buzz_chrip", 32'({buzzer_enable, chrip_mode}), (e >= Live) ? 32'd3 : 32'd0);
    end

    // Reset while a switch 1 -> 4 is pending
    goto_mode(3'd1);
    for (int i = 0; i < Stable + 3; i++) cycle("f_req", 3'd4, 1'b0);
    apply_reset();
    for (int i = 0; i < Live + 2; i++) begin
      cycle("f_model", 3'd0, 1'b0);
      check("f_no_change", 32'(mode_changed), 32'd0);
    end

    // Random traffic
    for (int blk = 0; blk < 160; blk++) begin
      s   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 20);
      if ($urandom_range(0, 24) == 0) apply_reset();
      for (int k = 0; k < len; k++) begin
        cycle("rand", s, 1'($urandom_range(0, 39) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
